// File: rtl/cmd_stream_pkg.sv
// Shared types, keyword constants and ASCII helpers for the command stream decoder.
package cmd_stream_pkg;

  typedef enum logic [2:0] {
    RespOk          = 3'd0,
    RespOkRdata     = 3'd1,
    RespErrSyntax   = 3'd2,
    RespErrOverflow = 3'd3,
    RespErrTimeout  = 3'd4
  } resp_code_e;

  typedef enum logic [2:0] {
    StRxKey,
    StRxAddr,
    StRxData,
    StDiscard,
    StExec,
    StResp
  } state_e;

  // Keywords are right-justified: letters shift in at the low end.
  localparam logic [39:0] KwStart = "start";
  localparam logic [39:0] KwStop  = {8'h00, "stop"};
  localparam logic [39:0] KwReset = "reset";
  localparam logic [39:0] KwRead  = {8'h00, "read"};
  localparam logic [39:0] KwWrite = "write";

  localparam logic [7:0] ChLf    = 8'h0A;
  localparam logic [7:0] ChCr    = 8'h0D;
  localparam logic [7:0] ChSpace = 8'h20;

  function automatic logic is_hex(input logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) ||
           (c >= 8'h61 && c <= 8'h66);
  endfunction

  function automatic logic is_lower(input logic [7:0] c);
    return (c >= 8'h61 && c <= 8'h7A);
  endfunction

  // Letters A-F/a-f have low nibble 1..6, so adding 9 yields 10..15.
  function automatic logic [3:0] hex_nibble(input logic [7:0] c);
    return (c <= 8'h39) ? c[3:0] : c[3:0] + 4'd9;
  endfunction

endpackage

// File: rtl/cmd_stream_decoder_hex_accum.sv
// Hex argument accumulator: shifts nibbles in MSB-first and tracks the digit count.
module hex_accum #(
  parameter int unsigned W = 16
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         clr,
  input  logic         shift,
  input  logic [3:0]   nibble,
  output logic [W-1:0] value,
  output logic         empty,
  output logic         full
);

  localparam int unsigned Digits = W / 4;
  localparam int unsigned CntW   = $clog2(Digits + 1);

  logic [W-1:0]    value_q;
  logic [CntW-1:0] cnt_q;

  // Value and digit count; a shift is refused once all W/4 digits are present.
  always_ff @(posedge Clk) begin
    if (Rst || clr) begin
      value_q <= '0;
      cnt_q   <= '0;
    end else if (shift && !full) begin
      value_q <= {value_q[W-5:0], nibble};
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  assign value = value_q;
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CntW'(Digits));

endmodule

// File: rtl/cmd_stream_decoder.sv
// ASCII command decoder: parses "read/write/start/stop/reset" lines from a byte stream,
// runs one bus cycle per command and returns a response record.
// Optional bus timeout: define CMD_STREAM_DECODER_TIMEOUT_EN.
module cmd_stream_decoder
  import cmd_stream_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_MAX   = 32,
  parameter int unsigned TMO_CYCLES = 1024
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              S_axis_tvalid,
  input  logic [7:0]        S_axis_tdata,
  output logic              S_axis_tready,
  output logic [ADDR_W-1:0] Addr,
  output logic [DATA_W-1:0] Wdata,
  output logic              We,
  output logic              Cs,
  input  logic              Ack,
  input  logic [DATA_W-1:0] Rdata,
  output logic              Irq,
  output logic              Rst_req,
  output logic              Resp_valid,
  input  logic              Resp_ready,
  output logic [2:0]        Resp_code,
  output logic [DATA_W-1:0] Resp_data
);

  localparam int unsigned LnW = $clog2(LINE_MAX + 1);

  if ((ADDR_W % 4) != 0 || ADDR_W < 4 || ADDR_W > 32) begin : g_bad_addr_w
    $error("ADDR_W must be a multiple of 4 in 4..32");
  end
  if ((DATA_W % 4) != 0 || DATA_W < 8 || DATA_W > 64) begin : g_bad_data_w
    $error("DATA_W must be a multiple of 4 in 8..64");
  end
  if (LINE_MAX < 2 || TMO_CYCLES < 1) begin : g_bad_limits
    $error("LINE_MAX must be >= 2 and TMO_CYCLES >= 1");
  end

  state_e            state_q, state_d;
  logic [39:0]       key_q, key_d;
  logic [2:0]        key_len_q, key_len_d;
  logic              wr_q, wr_d;
  logic [LnW-1:0]    line_cnt_q, line_cnt_d;
  resp_code_e        code_q, code_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              irq_q, irq_d;
  logic              rst_req_q, rst_req_d;
  logic              cs_q, cs_d;
  logic              we_q, we_d;

  logic addr_clr, addr_shift, addr_empty, addr_full;
  logic data_clr, data_shift, data_empty, data_full;
  logic byte_fire, is_lf, is_cr, is_sp, is_lc, is_hx, line_full, tmo_hit;
  logic [3:0] nibble;

  assign S_axis_tready = (state_q == StRxKey) || (state_q == StRxAddr) ||
                         (state_q == StRxData) || (state_q == StDiscard);
  assign byte_fire = S_axis_tvalid && S_axis_tready;
  assign is_lf     = (S_axis_tdata == ChLf);
  assign is_cr     = (S_axis_tdata == ChCr);
  assign is_sp     = (S_axis_tdata == ChSpace);
  assign is_lc     = is_lower(S_axis_tdata);
  assign is_hx     = is_hex(S_axis_tdata);
  assign nibble    = hex_nibble(S_axis_tdata);
  // This byte would be the LINE_MAX-th without a terminating LF.
  assign line_full = byte_fire && !is_lf && (line_cnt_q == LnW'(LINE_MAX - 1));

`ifdef CMD_STREAM_DECODER_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TMO_CYCLES + 1);
  logic [TmoW-1:0] tmo_q;

  // Cycles spent in EXEC; restarts whenever EXEC is left.
  always_ff @(posedge Clk) begin
    if (Rst || state_q != StExec) tmo_q <= '0;
    else                          tmo_q <= tmo_q + 1'b1;
  end
  assign tmo_hit = (state_q == StExec) && (tmo_q == TmoW'(TMO_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // Parser, bus sequencing and response next-state logic.
  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    key_len_d  = key_len_q;
    wr_d       = wr_q;
    line_cnt_d = line_cnt_q;
    code_d     = code_q;
    rdata_d    = rdata_q;
    irq_d      = irq_q;
    rst_req_d  = 1'b0;
    cs_d       = 1'b0;
    we_d       = 1'b0;
    addr_clr   = 1'b0;
    addr_shift = 1'b0;
    data_clr   = 1'b0;
    data_shift = 1'b0;

    if (byte_fire) begin
      if (is_lf)                                line_cnt_d = '0;
      else if (line_cnt_q != LnW'(LINE_MAX)) line_cnt_d = line_cnt_q + 1'b1;
    end

    unique case (state_q)
      StRxKey: begin
        if (byte_fire && !is_cr) begin
          if (is_lc) begin
            if (key_len_q == 3'd5) begin
              state_d = StDiscard;
              code_d  = RespErrSyntax;
            end else begin
              key_d     = {key_q[31:0], S_axis_tdata};
              key_len_d = key_len_q + 3'd1;
            end
          end else if (is_sp) begin
            addr_clr = 1'b1;
            if (key_q == KwRead) begin
              state_d = StRxAddr;
              wr_d    = 1'b0;
            end else if (key_q == KwWrite) begin
              state_d = StRxAddr;
              wr_d    = 1'b1;
            end else begin
              state_d = StDiscard;
              code_d  = RespErrSyntax;
            end
          end else if (is_lf) begin
            // An empty line stays in RX_KEY without a response.
            if (key_len_q != 3'd0) begin
              state_d = StResp;
              code_d  = RespOk;
              if (key_q == KwStart)      irq_d = 1'b0;
              else if (key_q == KwStop)  irq_d = 1'b1;
              else if (key_q == KwReset) rst_req_d = 1'b1;
              else                       code_d = RespErrSyntax;
            end
          end else begin
            state_d = StDiscard;
            code_d  = RespErrSyntax;
          end
        end
      end
      StRxAddr: begin
        if (byte_fire && !is_cr) begin
          if (is_hx) begin
            if (addr_full) begin
              state_d = StDiscard;
              code_d  = RespErrOverflow;
            end else begin
              addr_shift = 1'b1;
            end
          end else if (is_sp && wr_q && !addr_empty) begin
            state_d  = StRxData;
            data_clr = 1'b1;
          end else if (is_lf) begin
            if (wr_q || addr_empty) begin
              state_d = StResp;
              code_d  = RespErrSyntax;
            end else begin
              state_d = StExec;
            end
          end else begin
            state_d = StDiscard;
            code_d  = RespErrSyntax;
          end
        end
      end
      StRxData: begin
        if (byte_fire && !is_cr) begin
          if (is_hx) begin
            if (data_full) begin
              state_d = StDiscard;
              code_d  = RespErrOverflow;
            end else begin
              data_shift = 1'b1;
            end
          end else if (is_lf) begin
            if (data_empty) begin
              state_d = StResp;
              code_d  = RespErrSyntax;
            end else begin
              state_d = StExec;
            end
          end else begin
            state_d = StDiscard;
            code_d  = RespErrSyntax;
          end
        end
      end
      StDiscard: begin
        if (byte_fire && is_lf) state_d = StResp;
      end
      StExec: begin
        cs_d = 1'b1;
        we_d = wr_q;
        // Ack is only honoured while Cs is up; it wins over a simultaneous timeout.
        if (cs_q && Ack) begin
          cs_d    = 1'b0;
          we_d    = 1'b0;
          state_d = StResp;
          code_d  = wr_q ? RespOk : RespOkRdata;
          rdata_d = wr_q ? '0 : Rdata;
        end else if (tmo_hit) begin
          cs_d    = 1'b0;
          we_d    = 1'b0;
          state_d = StResp;
          code_d  = RespErrTimeout;
          rdata_d = '0;
        end
      end
      StResp: begin
        if (Resp_ready) begin
          state_d   = StRxKey;
          key_d     = '0;
          key_len_d = '0;
          wr_d      = 1'b0;
          code_d    = RespOk;
          rdata_d   = '0;
          addr_clr  = 1'b1;
          data_clr  = 1'b1;
        end
      end
      default: state_d = StRxKey;
    endcase

    // Line-length overflow overrides whatever the byte would otherwise have done.
    if (line_full && (state_q == StRxKey || state_q == StRxAddr || state_q == StRxData)) begin
      state_d = StDiscard;
      code_d  = RespErrOverflow;
    end
  end

  // State and output registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= StRxKey;
      key_q      <= '0;
      key_len_q  <= '0;
      wr_q       <= 1'b0;
      line_cnt_q <= '0;
      code_q     <= RespOk;
      rdata_q    <= '0;
      irq_q      <= 1'b1;
      rst_req_q  <= 1'b0;
      cs_q       <= 1'b0;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      key_len_q  <= key_len_d;
      wr_q       <= wr_d;
      line_cnt_q <= line_cnt_d;
      code_q     <= code_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
      rst_req_q  <= rst_req_d;
      cs_q       <= cs_d;
      we_q       <= we_d;
    end
  end

  hex_accum #(.W(ADDR_W)) u_addr_accum (
    .Clk    (Clk),
    .Rst    (Rst),
    .clr    (addr_clr),
    .shift  (addr_shift),
    .nibble (nibble),
    .value  (Addr),
    .empty  (addr_empty),
    .full   (addr_full)
  );

  hex_accum #(.W(DATA_W)) u_data_accum (
    .Clk    (Clk),
    .Rst    (Rst),
    .clr    (data_clr),
    .shift  (data_shift),
    .nibble (nibble),
    .value  (Wdata),
    .empty  (data_empty),
    .full   (data_full)
  );

  assign We         = we_q;
  assign Cs         = cs_q;
  assign Irq        = irq_q;
  assign Rst_req    = rst_req_q;
  assign Resp_valid = (state_q == StResp);
  assign Resp_code  = code_q;
  assign Resp_data  = rdata_q;

endmodule
